// File: rtl/snes_pad_emulator.sv
// Device-side SNES gamepad: answers a host latch/clock read with a serial button frame.
// Optional `SNES_PAD_FILTER_EN adds a 3-sample majority filter after each synchronizer.
`timescale 1ns/1ps
module snes_pad_emulator #(
    parameter int NUM_BUTTONS     = 12,
    parameter int FRAME_BITS      = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW_DATA = 1
) (
    input  logic                   clk_50,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic                   latch_snes,
    input  logic                   clk_snes,
    output logic                   data_snes,
    output logic                   busy,
    output logic                   read_done
);

    localparam int   IDX_W        = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic RELEASED_LVL = (ACTIVE_LOW_DATA != 0) ? 1'b1 : 1'b0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);
    localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(FRAME_BITS - 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] latch_sync_q;
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic                   latch_s;
    logic                   clk_s;
    logic                   latch_prev_q;
    logic                   clk_prev_q;
    logic                   latch_rise;
    logic                   latch_fall;
    logic                   clk_rise;

    state_t                 state_q;
    logic [FRAME_BITS-1:0]  shift_q;
    logic [FRAME_BITS-1:0]  frame_d;
    logic [IDX_W-1:0]       bit_idx_q;
    logic                   busy_q;
    logic                   read_done_q;
    logic                   data_q;

    function automatic logic wire_level(input logic b);
        return (ACTIVE_LOW_DATA != 0) ? ~b : b;
    endfunction

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            latch_sync_q <= '0;
            clk_sync_q   <= '1;
        end else begin
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], latch_snes};
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], clk_snes};
        end
    end

`ifdef SNES_PAD_FILTER_EN
    logic [1:0] latch_hist_q;
    logic [1:0] clk_hist_q;
    logic       latch_filt_q;
    logic       clk_filt_q;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Window is the live synchronizer output plus its two previous samples.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            latch_hist_q <= '0;
            latch_filt_q <= 1'b0;
            clk_hist_q   <= '1;
            clk_filt_q   <= 1'b1;
        end else begin
            latch_hist_q <= {latch_hist_q[0], latch_sync_q[SYNC_STAGES-1]};
            latch_filt_q <= maj3(latch_sync_q[SYNC_STAGES-1], latch_hist_q[0], latch_hist_q[1]);
            clk_hist_q   <= {clk_hist_q[0], clk_sync_q[SYNC_STAGES-1]};
            clk_filt_q   <= maj3(clk_sync_q[SYNC_STAGES-1], clk_hist_q[0], clk_hist_q[1]);
        end
    end

    assign latch_s = latch_filt_q;
    assign clk_s   = clk_filt_q;
`else
    assign latch_s = latch_sync_q[SYNC_STAGES-1];
    assign clk_s   = clk_sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            latch_prev_q <= 1'b0;
            clk_prev_q   <= 1'b1;
        end else begin
            latch_prev_q <= latch_s;
            clk_prev_q   <= clk_s;
        end
    end

    assign latch_rise = latch_s & ~latch_prev_q;
    assign latch_fall = ~latch_s & latch_prev_q;
    assign clk_rise   = clk_s & ~clk_prev_q;

    always_comb begin
        frame_d                  = '0;
        frame_d[NUM_BUTTONS-1:0] = buttons;
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            busy_q      <= 1'b0;
            read_done_q <= 1'b0;
            data_q      <= RELEASED_LVL;
        end else begin
            read_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    data_q <= RELEASED_LVL;
                    if (latch_s) begin
                        state_q   <= ST_LOAD;
                        shift_q   <= frame_d;
                        bit_idx_q <= '0;
                    end
                end
                ST_LOAD: begin
                    shift_q   <= frame_d;
                    bit_idx_q <= '0;
                    data_q    <= wire_level(shift_q[0]);
                    if (latch_fall) begin
                        state_q <= ST_SHIFT;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    data_q <= wire_level(shift_q[0]);
                    // A new latch outranks a simultaneous clock edge.
                    if (latch_rise) begin
                        state_q   <= ST_LOAD;
                        shift_q   <= frame_d;
                        bit_idx_q <= '0;
                        busy_q    <= 1'b0;
                    end else if (clk_rise) begin
                        if (bit_idx_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                        end else begin
                            shift_q   <= {1'b0, shift_q[FRAME_BITS-1:1]};
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                            if (bit_idx_q == PRE_LAST) begin
                                read_done_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    data_q <= RELEASED_LVL;
                    if (latch_s) begin
                        state_q   <= ST_LOAD;
                        shift_q   <= frame_d;
                        bit_idx_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    data_q  <= RELEASED_LVL;
                end
            endcase
        end
    end

    assign data_snes = data_q;
    assign busy      = busy_q;
    assign read_done = read_done_q;

endmodule

// File: tb/tb_snes_pad_emulator.sv
// Directed bench for snes_pad_emulator: host-style reads, relatch, reset and glitch cases.
`timescale 1ns/1ps
module tb_snes_pad_emulator;

    localparam int SYNC = 2;
`ifdef SNES_PAD_FILTER_EN
    localparam int LAT  = SYNC + 3;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT  = SYNC + 1;
    localparam bit FILT = 1'b0;
`endif

    logic        clk_50;
    logic        reset_n;
    logic [11:0] buttons;
    logic        latch_snes;
    logic        clk_snes;
    logic        data_snes;
    logic        busy;
    logic        read_done;

    int n_tests = 0;
    int n_fail  = 0;
    int rd_cnt  = 0;

    snes_pad_emulator #(
        .NUM_BUTTONS    (12),
        .FRAME_BITS     (16),
        .SYNC_STAGES    (SYNC),
        .ACTIVE_LOW_DATA(1)
    ) dut (
        .clk_50    (clk_50),
        .reset_n   (reset_n),
        .buttons   (buttons),
        .latch_snes(latch_snes),
        .clk_snes  (clk_snes),
        .data_snes (data_snes),
        .busy      (busy),
        .read_done (read_done)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    always @(negedge clk_50) begin
        if (read_done === 1'b1) rd_cnt <= rd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Host read: latch pulse of 2*half, then nclk clock pulses; sample just before each fall.
    task automatic read_frame(input int half, input int nclk, input int chg_at,
                              input logic [11:0] chg_val, output logic [15:0] raw);
        raw = '0;
        latch_snes = 1'b1;
        #(2 * half);
        latch_snes = 1'b0;
        #(half);
        check("busy_in_shift", busy, 1);
        for (int k = 0; k < nclk; k++) begin
            if (k == chg_at) buttons = chg_val;
            raw[k]   = data_snes;
            clk_snes = 1'b0;
            #(half);
            clk_snes = 1'b1;
            #(half);
        end
    endtask

    logic [15:0] raw;
    int          base;

    initial begin
        buttons    = '0;
        latch_snes = 1'b0;
        clk_snes   = 1'b1;
        reset_n    = 1'b0;
        repeat (3) @(negedge clk_50);
        check("rst_data", data_snes, 1);
        check("rst_busy", busy, 0);
        check("rst_done", read_done, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_50);
        check("idle_data", data_snes, 1);

        // B only, real host timing
        buttons = 12'h001;
        base = rd_cnt;
        read_frame(6000, 16, -1, 12'h000, raw);
        check("t1_raw", raw, 16'hFFFE);
        check("t1_rd_cnt", rd_cnt - base, 1);
        check("t1_busy_end", busy, 0);
        check("t1_data_end", data_snes, 1);

        buttons = 12'hA5C;
        base = rd_cnt;
        read_frame(500, 16, -1, 12'h000, raw);
        check("t2_raw", raw, 16'hF5A3);
        check("t2_rd_cnt", rd_cnt - base, 1);

        // Host stops after 5 clocks, then relatches
        buttons = 12'h020;
        base = rd_cnt;
        read_frame(500, 5, -1, 12'h000, raw);
        check("t3_part_raw", raw, 16'h001F);
        #500;
        check("t3_hold_data", data_snes, 0);
        check("t3_hold_busy", busy, 1);
        buttons = 12'h002;
        @(negedge clk_50);
        latch_snes = 1'b1;
        repeat (LAT) @(negedge clk_50);
        check("t3_relatch_early", data_snes, 0);
        @(negedge clk_50);
        check("t3_relatch_bit0", data_snes, 1);
        check("t3_relatch_busy", busy, 0);
        check("t3_abort_rd", rd_cnt - base, 0);
        read_frame(500, 16, -1, 12'h000, raw);
        check("t3_full_raw", raw, 16'hFFFD);
        check("t3_full_rd", rd_cnt - base, 1);

        // Buttons change mid-frame
        buttons = 12'h000;
        base = rd_cnt;
        read_frame(500, 16, 8, 12'hFFF, raw);
        check("t4_raw_a", raw, 16'hFFFF);
        read_frame(500, 16, -1, 12'h000, raw);
        check("t4_raw_b", raw, 16'hF000);
        check("t4_rd_cnt", rd_cnt - base, 2);

        // Asynchronous reset mid-frame
        buttons = 12'hFFF;
        base = rd_cnt;
        read_frame(500, 3, -1, 12'h000, raw);
        check("t5_part_raw", raw, 16'h0000);
        #500;
        check("t5_pre_data", data_snes, 0);
        #3;
        reset_n = 1'b0;
        #1;
        check("t5_rst_data", data_snes, 1);
        check("t5_rst_busy", busy, 0);
        @(negedge clk_50);
        reset_n = 1'b1;
        repeat (4) begin
            clk_snes = 1'b0;
            #500;
            clk_snes = 1'b1;
            #500;
        end
        check("t5_nolatch_data", data_snes, 1);
        check("t5_nolatch_busy", busy, 0);
        check("t5_rd_cnt", rd_cnt - base, 0);

        // One-cycle low glitch on clk_snes while in SHIFT
        buttons = 12'h002;
        read_frame(500, 0, -1, 12'h000, raw);
        check("t6_bit0", data_snes, 1);
        @(negedge clk_50);
        clk_snes = 1'b0;
        @(negedge clk_50);
        clk_snes = 1'b1;
        repeat (10) @(negedge clk_50);
        check("t6_glitch", data_snes, FILT ? 1 : 0);
        check("t6_busy", busy, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/snes_pad_emulator.md
Name: snes_pad_emulator

Overview:
Device-side SNES controller emulator. It answers a host's latch/clock read cycle by shifting a 16-bit button frame out on the serial data line. It sits on the FPGA pad-connector side and lets the DE1-SoC act as a SNES gamepad, driven by switches, keys or the HPS. It is the counterpart of the host-side SNES_FSM reader already in the design.

Parameters:
NUM_BUTTONS, 12, number of live button bits; frame bits NUM_BUTTONS..FRAME_BITS-1 are sent as "released".
FRAME_BITS, 16, bits per read frame.
SYNC_STAGES, 2, flip-flop stages on latch_snes and clk_snes (minimum 2).
ACTIVE_LOW_DATA, 1, 1: wire level is 0 for a pressed button (real pad); 0: wire level equals the button bit.

Ports:
clk_50  input  1  system clock, 50 MHz.
reset_n  input  1  asynchronous, active-low reset.
buttons  input  NUM_BUTTONS  button state, 1 = pressed; bit 0 = B, shifted first.
latch_snes  input  1  host latch, asynchronous to clk_50.
clk_snes  input  1  host serial clock, asynchronous to clk_50, idles high.
data_snes  output  1  serial data to host, registered.
busy  output  1  high from latch falling edge until the frame completes or is aborted.
read_done  output  1  one-cycle pulse when bit FRAME_BITS-1 is presented.

Behaviour:
- Reset (async assert, sync release): state IDLE, shift register all 0 (released), bit_idx 0, busy 0, read_done 0, data_snes at released level (1 when ACTIVE_LOW_DATA=1). Synchronizer flops reset to 0 for latch and 1 for clock.
- latch_snes and clk_snes pass through SYNC_STAGES flops each. Edges are detected against a registered copy of the synchronizer output.
- Frame vector: {(FRAME_BITS-NUM_BUTTONS) zeros, buttons}. Zeros mean released.
- Wire level: data_snes = ACTIVE_LOW_DATA ? ~shift[0] : shift[0], registered.
- FSM states:
  - IDLE: synchronized latch high -> LOAD.
  - LOAD: reload the shift register from the frame vector every cycle, so the last sample before the latch falls wins. bit_idx=0. data_snes presents bit 0. Latch falling -> SHIFT, busy=1.
  - SHIFT: on each synchronized clk_snes rising edge, shift right with 0 fill and increment bit_idx. When bit_idx becomes FRAME_BITS-1, pulse read_done for 1 cycle. On the rising edge after that -> DONE.
  - DONE: data_snes at released level, busy=0. Latch high -> LOAD.
- clk_snes falling edges never change data. The host samples on the falling edge, and data is stable since the preceding rising edge.
- Latch rising in SHIFT (abort or re-read) -> LOAD immediately, busy=0, no read_done.
- Latch and clock edges in the same cycle: latch takes priority and the clock edge is ignored.
- Clock edges in IDLE, LOAD or DONE are ignored.
- Host stops early: stay in SHIFT holding the current bit until the next latch.
- Latency: a transition on latch_snes/clk_snes first sampled at clk_50 edge N is reflected on data_snes at edge N+SYNC_STAGES+1.
- buttons changes during SHIFT do not affect the frame in flight.

Optional Feature:
SNES_PAD_FILTER_EN: when defined, a 3-sample majority filter follows each synchronizer, rejecting single-cycle glitches on long cable runs. Latency becomes SYNC_STAGES+3. When undefined, there is no filter and latency is SYNC_STAGES+1.

Test Plan:
- buttons=12'h001 (B), host-style read (12 us latch, 16 clocks of 6 us/6 us), ACTIVE_LOW_DATA=1 -> at successive clk falling edges data_snes reads 0,1,1,...,1 (16 samples); read_done pulses once; busy=0 after the 16th rising edge.
- buttons=12'hA5C, same read -> samples equal ~{4'b0000,12'hA5C} LSB first; a reader storing raw bits reconstructs 16'hF5A3.
- Relatch after the 5th clock rising edge -> LOAD, data_snes shows the new bit 0 within SYNC_STAGES+1 cycles, no read_done; a full frame follows correctly.
- Change buttons from 12'h000 to 12'hFFF mid-SHIFT -> the current frame still reads all released; the next frame reads all pressed.
- Assert reset_n=0 mid-frame -> data_snes=1, busy=0 immediately (asynchronously); after release, clocks without a latch leave data_snes=1.
- With SNES_PAD_FILTER_EN, a 1-cycle (20 ns) clk_snes glitch in SHIFT -> bit_idx unchanged; without the macro, the glitch advances bit_idx by 1.
